// File: rtl/mulacc_top_if.sv
// -----------------------------------------------------------------------------
// mulacc_top_if
//   Start/ready handshake and operand/result bus for the sequential
//   multiply-accumulate unit.
//
//   start   : request to begin an operation (sampled only while idle)
//   MBus    : 16-bit multiplicand (the divisor when rebuilding a dividend)
//   QBus    : 16-bit multiplier   (the quotient)
//   RBus    : 16-bit addend       (the remainder)
//   product : 32-bit result, valid when ready pulses
//   busy    : operation in progress (CALC or DONE)
//   ready   : one-cycle completion pulse
//
//   master : the requester (drives operands and start)
//   slave  : the multiply-accumulate unit
// -----------------------------------------------------------------------------
interface mulacc_top_if;
    logic        start;
    logic [15:0] MBus;
    logic [15:0] QBus;
    logic [15:0] RBus;
    logic [31:0] product;
    logic        busy;
    logic        ready;

    modport master (
        output start, MBus, QBus, RBus,
        input  product, busy, ready
    );

    modport slave (
        input  start, MBus, QBus, RBus,
        output product, busy, ready
    );
endinterface

// File: rtl/mulacc_top.sv
// -----------------------------------------------------------------------------
// mulacc_top
//   Sequential 16x16 unsigned multiply-accumulate: product = MBus * QBus + RBus.
//   Radix-2 shift-add, one multiplier bit per cycle, stopping as soon as the
//   multiplier's most significant one has been consumed. A zero multiplier
//   skips the datapath entirely and returns the addend.
//
//   clk : single clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : mulacc_top_if slave port (start/MBus/QBus/RBus in,
//         product/busy/ready out)
// -----------------------------------------------------------------------------
module mulacc_top (
    input  logic         clk,
    input  logic         rst,
    mulacc_top_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] mx_q,      mx_d;       // multiplicand, shifted left each step
    logic [15:0] qr_q,      qr_d;       // multiplier, shifted right each step
    logic [31:0] acc_q,     acc_d;      // running sum, seeded with the addend
    logic [31:0] product_q, product_d;
    logic [31:0] sum;                   // this step's accumulator value

    // NOTE: every variable gets its hold value before the case statement, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        mx_d      = mx_q;
        qr_d      = qr_q;
        acc_d     = acc_q;
        product_d = product_q;
        sum       = qr_q[0] ? (acc_q + mx_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mx_d  = {16'b0, bus.MBus};
                    qr_d  = bus.QBus;
                    acc_d = {16'b0, bus.RBus};
                    if (bus.QBus == 16'd0) begin
                        product_d = {16'b0, bus.RBus};
                        state_d   = DONE;
                    end else begin
                        state_d   = CALC;
                    end
                end
            end

            CALC: begin
                acc_d = sum;
                mx_d  = mx_q << 1;
                qr_d  = qr_q >> 1;
                // No ones left above bit 0: this step finishes the product,
                // so publish the same-cycle sum rather than waiting a cycle.
                if (qr_q[15:1] == 15'd0) begin
                    product_d = sum;
                    state_d   = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: these are few plain registers, not a memory array, so all of them
    // are cleared by the reset; an abort leaves no stale partial result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mx_q      <= '0;
            qr_q      <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            mx_q      <= mx_d;
            qr_q      <= qr_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    // Status outputs are pure state decodes: no combinational input path.
    assign bus.product = product_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.ready   = (state_q == DONE);

endmodule

// File: tb/tb_mulacc_top.sv
// -----------------------------------------------------------------------------
// tb_mulacc_top
//   Directed bench for mulacc_top. Inputs change on the falling edge and
//   outputs are sampled on the falling edge, half a cycle from the active edge.
//   Latency is counted in rising edges after the accepting edge E0 up to the
//   edge that enters DONE (k+1 for a multiplier whose top one is bit k, 0 for
//   a zero multiplier).
// -----------------------------------------------------------------------------
module tb_mulacc_top;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    mulacc_top_if bus ();

    mulacc_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Edges from E0 to the edge entering DONE.
    function automatic int exp_latency(input logic [15:0] q);
        int k;
        k = -1;
        for (int i = 0; i < 16; i++) if (q[i]) k = i;
        return k + 1;
    endfunction

    // Present operands with start at a falling edge, let E0 accept them,
    // drop start at the next falling edge (the first cycle after E0).
    task automatic launch(input logic [15:0] m, input logic [15:0] q, input logic [15:0] r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.MBus  = m;
        bus.QBus  = q;
        bus.RBus  = r;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at a falling edge that is lat0 edges after E0. Bounded wait for
    // ready; reports latency and the number of busy cycles seen on the way.
    task automatic wait_done(input string tag, input int lat0, output logic [31:0] p,
                             output int lat, output int busy_n);
        bit seen;
        seen   = 1'b0;
        lat    = lat0;
        busy_n = 0;
        p      = 'x;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) busy_n++;
            if (bus.ready) begin
                p    = bus.product;
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, " ready seen"}, 32'(seen), 32'd1);
    endtask

    logic [31:0] p;
    int          lat;
    int          busy_n;
    int          ready_cnt;
    int          busy_cnt;
    logic [15:0] a, d, q, r;

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        bus.MBus  = '0;
        bus.QBus  = '0;
        bus.RBus  = '0;
        rst       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset product", bus.product, 32'h0);
        check("reset busy",    32'(bus.busy),  32'd0);
        check("reset ready",   32'(bus.ready), 32'd0);
        rst = 1'b1;

        // Small operands: 7*5+3 = 38, multiplier top one at bit 2.
        launch(16'h0007, 16'h0005, 16'h0003);
        wait_done("small", 0, p, lat, busy_n);
        check("small product", p, 32'h0000_0026);
        check("small latency", 32'(lat), 32'd3);
        check("small busy cycles", 32'(busy_n), 32'd4);
        @(negedge clk);
        check("small ready pulse width", 32'(bus.ready), 32'd0);
        check("small busy after", 32'(bus.busy), 32'd0);
        check("small product held", bus.product, 32'h0000_0026);

        // Zero multiplier: addend passes straight through, DONE at E0.
        launch(16'h1234, 16'h0000, 16'h00FF);
        wait_done("zeroq", 0, p, lat, busy_n);
        check("zeroq product", p, 32'h0000_00FF);
        check("zeroq latency", 32'(lat), 32'd0);
        check("zeroq busy cycles", 32'(busy_n), 32'd1);

        // Maximum operands: FFFF*FFFF+FFFF = FFFF0000, 16 CALC cycles.
        launch(16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_done("max", 0, p, lat, busy_n);
        check("max product", p, 32'hFFFF_0000);
        check("max latency", 32'(lat), 32'd16);
        check("max busy cycles", 32'(busy_n), 32'd17);

        // Multiplier of 1: single CALC step.
        launch(16'hABCD, 16'h0001, 16'h0011);
        wait_done("q1", 0, p, lat, busy_n);
        check("q1 product", p, 32'h0000_ABDE);
        check("q1 latency", 32'(lat), 32'd1);

        // Start pulsed and buses scrambled during CALC: no effect.
        launch(16'h0100, 16'h8001, 16'h0000);
        bus.start = 1'b1;
        bus.MBus  = 16'hFFFF;
        bus.QBus  = 16'h0003;
        bus.RBus  = 16'h5555;
        @(negedge clk);
        bus.MBus  = 16'h0F0F;
        bus.QBus  = 16'h0000;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore", 2, p, lat, busy_n);
        check("ignore product", p, 32'h0080_0100);
        check("ignore latency", 32'(lat), 32'd16);
        busy_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
        end
        check("ignore no second op", 32'(busy_cnt), 32'd0);
        check("ignore product held", bus.product, 32'h0080_0100);

        // Start held high: re-accepted after one idle cycle.
        launch(16'h0003, 16'h0001, 16'h0001);
        bus.start = 1'b1;
        wait_done("b2b first", 0, p, lat, busy_n);
        check("b2b first product", p, 32'h0000_0004);
        @(negedge clk);
        check("b2b idle gap busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b second accepted", 32'(bus.busy), 32'd1);
        wait_done("b2b second", 1, p, lat, busy_n);
        check("b2b second product", p, 32'h0000_0004);

        // Asynchronous reset mid-CALC of a long operation.
        launch(16'h1111, 16'hF000, 16'h2222);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset product", bus.product, 32'h0);
        check("midreset busy",    32'(bus.busy),  32'd0);
        check("midreset ready",   32'(bus.ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ready_cnt = 0;
        busy_cnt  = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.ready) ready_cnt++;
            if (bus.busy)  busy_cnt++;
        end
        check("postreset no ready", 32'(ready_cnt), 32'd0);
        check("postreset idle",     32'(busy_cnt),  32'd0);

        // Divider round-trip: 0xBEEF / 0x0123 -> quotient 167, remainder 282.
        launch(16'h0123, 16'd167, 16'd282);
        wait_done("rt beef", 0, p, lat, busy_n);
        check("rt beef product", p, 32'h0000_BEEF);
        check("rt beef latency", 32'(lat), 32'd8);

        // Random round-trips rebuild the dividend from divisor/quotient/remainder.
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom_range(0, 65535));
            d = 16'($urandom_range(1, 65535));
            q = a / d;
            r = a % d;
            launch(d, q, r);
            wait_done("rt rand", 0, p, lat, busy_n);
            check($sformatf("rt rand %0d product (a=%h d=%h)", i, a, d), p, {16'b0, a});
            check($sformatf("rt rand %0d latency", i), 32'(lat), 32'(exp_latency(q)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
